// File: rtl/gerador_de_ataque_pkg.sv
// rtl/gerador_de_ataque_pkg.sv - shared board size, FSM encoding and cell indexing
package gerador_de_ataque_pkg;

  localparam int N_COLUNAS = 5;
  localparam int N_LINHAS  = 7;
  localparam int N_CELULAS = N_COLUNAS * N_LINHAS;

  typedef enum logic [2:0] {
    OCIOSO,
    VALIDA,
    EMITE,
    ESPERA,
    FIM
  } estado_t;

  // Column-major cell index, shared with the manager and display.
  function automatic logic [5:0] indice_celula(input logic [2:0] coluna, input logic [2:0] linha);
    return 6'(coluna) * 6'(N_LINHAS) + 6'(linha);
  endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// rtl/sincroniza_borda.sv - two-flop synchronizer with rising-edge detector
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic borda
);

  logic meta;
  logic estavel;
  logic anterior;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      estavel  <= 1'b0;
      anterior <= 1'b0;
    end else begin
      meta     <= entrada;
      estavel  <= meta;
      anterior <= estavel;
    end
  end

  assign borda = estavel & ~anterior;

endmodule

// File: rtl/gerador_de_ataque.sv
// rtl/gerador_de_ataque.sv - cursor, shot sequencing and win/loss tracking for the attack initiator
module gerador_de_ataque
  import gerador_de_ataque_pkg::*;
#(
  parameter int MAX_TIROS     = 20,
  parameter int CELULAS_NAVIO = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       btnColuna,
  input  logic       btnLinha,
  input  logic       btnConfirmar,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic       confirmar,
  output logic       rejeitado,
  output logic [5:0] tirosRestantes,
  output logic [5:0] acertos,
  output logic       vitoria,
  output logic       derrota
);

  localparam logic [5:0] TIROS_INICIAIS = 6'(MAX_TIROS);
  localparam logic [5:0] ALVO_ACERTOS   = 6'(CELULAS_NAVIO);
  localparam logic [2:0] ULTIMA_COLUNA  = 3'(N_COLUNAS - 1);
  localparam logic [2:0] ULTIMA_LINHA   = 3'(N_LINHAS - 1);

  logic borda_coluna;
  logic borda_linha;
  logic borda_confirmar;

  sincroniza_borda u_sinc_coluna (
    .clock   (clock),
    .reset   (reset),
    .entrada (btnColuna),
    .borda   (borda_coluna)
  );

  sincroniza_borda u_sinc_linha (
    .clock   (clock),
    .reset   (reset),
    .entrada (btnLinha),
    .borda   (borda_linha)
  );

  sincroniza_borda u_sinc_confirmar (
    .clock   (clock),
    .reset   (reset),
    .entrada (btnConfirmar),
    .borda   (borda_confirmar)
  );

  logic [6:0]           mapa [N_COLUNAS];
  logic [N_CELULAS-1:0] disparados;
  logic [5:0]           indice;
  logic                 navio_alvo;
  estado_t              estado;

  assign mapa[0] = mapa0;
  assign mapa[1] = mapa1;
  assign mapa[2] = mapa2;
  assign mapa[3] = mapa3;
  assign mapa[4] = mapa4;

  // Cursor only moves in OCIOSO, so these stay fixed from VALIDA through ESPERA.
  assign indice     = indice_celula(coordColuna, coordLinha);
  assign navio_alvo = mapa[coordColuna][coordLinha];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= OCIOSO;
      coordColuna    <= '0;
      coordLinha     <= '0;
      confirmar      <= 1'b0;
      rejeitado      <= 1'b0;
      tirosRestantes <= TIROS_INICIAIS;
      acertos        <= '0;
      vitoria        <= 1'b0;
      derrota        <= 1'b0;
      disparados     <= '0;
    end else if (!enable) begin
      estado         <= OCIOSO;
      coordColuna    <= '0;
      coordLinha     <= '0;
      confirmar      <= 1'b0;
      rejeitado      <= 1'b0;
      tirosRestantes <= TIROS_INICIAIS;
      acertos        <= '0;
      vitoria        <= 1'b0;
      derrota        <= 1'b0;
      disparados     <= '0;
    end else begin
      rejeitado <= 1'b0;
      case (estado)
        OCIOSO: begin
          // A confirm edge wins over a simultaneous move: shoot where the cursor is now.
          if (borda_confirmar) begin
            estado <= VALIDA;
          end else begin
            if (borda_coluna) begin
              coordColuna <= (coordColuna == ULTIMA_COLUNA) ? 3'd0 : coordColuna + 3'd1;
            end
            if (borda_linha) begin
              coordLinha <= (coordLinha == ULTIMA_LINHA) ? 3'd0 : coordLinha + 3'd1;
            end
          end
        end
        VALIDA: begin
          if (disparados[indice]) begin
            rejeitado <= 1'b1;
            estado    <= OCIOSO;
          end else begin
            confirmar <= 1'b1;
            estado    <= EMITE;
          end
        end
        EMITE: begin
          confirmar          <= 1'b0;
          disparados[indice] <= 1'b1;
          tirosRestantes     <= tirosRestantes - 6'd1;
          if (navio_alvo) begin
            acertos <= acertos + 6'd1;
          end
          estado <= ESPERA;
        end
        ESPERA: begin
          if (acertos == ALVO_ACERTOS) begin
            vitoria <= 1'b1;
            estado  <= FIM;
          end else if (tirosRestantes == 6'd0) begin
            derrota <= 1'b1;
            estado  <= FIM;
          end else begin
            estado <= OCIOSO;
          end
        end
        FIM: begin
          estado <= FIM;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
